// File: rtl/lpif_link_seq_if.sv
// LPIF link sequencer control/status bundle.
// master: stimulus side; slave: lpif_link_seq.
interface lpif_link_seq_if;
   logic        link_en;
   logic        phy_ready;
   logic        rx_align_done;
   logic [15:0] settle_value;
   logic [15:0] align_timeout;
   logic        err_clear;
   logic        tx_online;
   logic        rx_online;
   logic        link_up;
   logic        link_err;
   logic [1:0]  retry_cnt;
   logic [2:0]  link_state;

   modport master (
      output link_en, phy_ready, rx_align_done,
      output settle_value, align_timeout, err_clear,
      input  tx_online, rx_online, link_up,
      input  link_err, retry_cnt, link_state
   );

   modport slave (
      input  link_en, phy_ready, rx_align_done,
      input  settle_value, align_timeout, err_clear,
      output tx_online, rx_online, link_up,
      output link_err, retry_cnt, link_state
   );
endinterface

// File: rtl/lpif_link_seq.sv
// LPIF link bring-up sequencer: PHY wait, tx settle, rx align, retrain.
// Ports: clk_wr, rst_wr_n (async low), lif (lpif_link_seq_if.slave).
module lpif_link_seq #(
   parameter int MAX_RETRY = 3
) (
   input  logic           clk_wr,
   input  logic           rst_wr_n,
   lpif_link_seq_if.slave lif
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_PHY   = 3'd1,
      ST_SETTLE     = 3'd2,
      ST_WAIT_ALIGN = 3'd3,
      ST_ONLINE     = 3'd4,
      ST_RETRY      = 3'd5,
      ST_ERROR      = 3'd6
   } state_e;

   localparam logic [1:0] MaxR = 2'(MAX_RETRY);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  retry_q, retry_d;
   logic        tx_q, rx_q, up_q, err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      // Disable aborts everything except ERROR.
      if (!lif.link_en && state_q != ST_ERROR) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_PHY;
            end
            ST_WAIT_PHY: begin
               if (lif.phy_ready) begin
                  state_d = ST_SETTLE;
                  cnt_d   = lif.settle_value;
               end
            end
            ST_SETTLE: begin
               if (cnt_q == 16'd0) begin
                  state_d = ST_WAIT_ALIGN;
                  cnt_d   = lif.align_timeout;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            ST_WAIT_ALIGN: begin
               // Lock wins over a simultaneous timeout.
               if (lif.rx_align_done) begin
                  state_d = ST_ONLINE;
               end else if (cnt_q == 16'd0) begin
                  state_d = ST_RETRY;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
            ST_ONLINE: begin
               if (!lif.rx_align_done || !lif.phy_ready) begin
                  state_d = ST_RETRY;
               end
            end
            ST_RETRY: begin
               if (retry_q >= MaxR) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d = ST_WAIT_PHY;
                  retry_d = retry_q + 2'd1;
               end
            end
            ST_ERROR: begin
               if (lif.err_clear) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      if (state_d == ST_IDLE) begin
         retry_d = 2'd0;
      end
   end

   // Outputs are registered from the next state so they
   // track state_q exactly and reset asynchronously.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
         retry_q <= 2'd0;
         tx_q    <= 1'b0;
         rx_q    <= 1'b0;
         up_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         tx_q    <= (state_d == ST_SETTLE)
                 || (state_d == ST_WAIT_ALIGN)
                 || (state_d == ST_ONLINE);
         rx_q    <= (state_d == ST_ONLINE);
         up_q    <= (state_d == ST_ONLINE);
         err_q   <= (state_d == ST_ERROR);
      end
   end

   assign lif.tx_online  = tx_q;
   assign lif.rx_online  = rx_q;
   assign lif.link_up    = up_q;
   assign lif.link_err   = err_q;
   assign lif.retry_cnt  = retry_q;
   assign lif.link_state = state_q;

endmodule

// File: tb/tb_lpif_link_seq.sv
// Scoreboard bench for lpif_link_seq.
// Expected state/retry per cycle queued at drive, checked at posedge+1.
module tb_lpif_link_seq;

   localparam logic [2:0] S_ID = 3'd0;
   localparam logic [2:0] S_WP = 3'd1;
   localparam logic [2:0] S_SE = 3'd2;
   localparam logic [2:0] S_WA = 3'd3;
   localparam logic [2:0] S_ON = 3'd4;
   localparam logic [2:0] S_RE = 3'd5;
   localparam logic [2:0] S_ER = 3'd6;

   typedef struct {
      logic [2:0] st;
      logic [1:0] rc;
   } exp_t;

   logic clk_wr;
   logic rst_wr_n;
   int   n_chk;
   int   n_err;
   exp_t sb[$];

   lpif_link_seq_if bus();

   lpif_link_seq #(.MAX_RETRY(3)) dut (
      .clk_wr   (clk_wr),
      .rst_wr_n (rst_wr_n),
      .lif      (bus.slave)
   );

   initial begin
      clk_wr = 1'b0;
      forever #5 clk_wr = ~clk_wr;
   end

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag,
                           input logic [2:0] st,
                           input logic [1:0] rc);
      logic tx;
      tx = (st == S_SE) || (st == S_WA) || (st == S_ON);
      chk({tag, ".state"}, 16'(bus.link_state), 16'(st));
      chk({tag, ".tx"}, 16'(bus.tx_online), 16'(tx));
      chk({tag, ".rx"}, 16'(bus.rx_online), 16'(st == S_ON));
      chk({tag, ".up"}, 16'(bus.link_up), 16'(st == S_ON));
      chk({tag, ".err"}, 16'(bus.link_err), 16'(st == S_ER));
      chk({tag, ".retry"}, 16'(bus.retry_cnt), 16'(rc));
   endtask

   always @(posedge clk_wr) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk_outs("cyc", e.st, e.rc);
      end
   end

   task automatic step(input logic [2:0] st,
                       input logic [1:0] rc);
      exp_t e;
      e.st = st;
      e.rc = rc;
      sb.push_back(e);
      @(posedge clk_wr);
      #2;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_wr_n              = 1'b0;
      bus.link_en       = 1'b1;
      bus.phy_ready     = 1'b1;
      bus.rx_align_done = 1'b0;
      bus.settle_value  = 16'd4;
      bus.align_timeout = 16'd10;
      bus.err_clear     = 1'b0;
      #12;
      chk_outs("rst", S_ID, 2'd0);
      rst_wr_n = 1'b1;
      #1;
      chk_outs("rel", S_ID, 2'd0);

      // Nominal bring-up; settle_value change mid-count ignored.
      step(S_WP, 2'd0);
      step(S_SE, 2'd0);
      bus.settle_value = 16'd100;
      repeat (4) step(S_SE, 2'd0);
      step(S_WA, 2'd0);
      step(S_WA, 2'd0);
      bus.rx_align_done = 1'b1;
      step(S_ON, 2'd0);
      step(S_ON, 2'd0);

      // Loss of lock for one cycle.
      bus.rx_align_done = 1'b0;
      step(S_RE, 2'd0);
      bus.rx_align_done = 1'b1;
      bus.settle_value  = 16'd0;
      step(S_WP, 2'd1);
      step(S_SE, 2'd1);
      step(S_WA, 2'd1);
      step(S_ON, 2'd1);

      // Disable from ONLINE clears retry count.
      bus.link_en = 1'b0;
      step(S_ID, 2'd0);

      // Four alignment timeouts end in ERROR.
      bus.link_en       = 1'b1;
      bus.rx_align_done = 1'b0;
      bus.align_timeout = 16'd2;
      step(S_WP, 2'd0);
      for (int f = 0; f < 4; f++) begin
         step(S_SE, 2'(f));
         repeat (3) step(S_WA, 2'(f));
         step(S_RE, 2'(f));
         if (f < 3) step(S_WP, 2'(f + 1));
         else       step(S_ER, 2'd3);
      end

      // ERROR ignores link_en; err_clear exits.
      bus.link_en = 1'b0;
      step(S_ER, 2'd3);
      bus.link_en = 1'b1;
      step(S_ER, 2'd3);
      bus.err_clear = 1'b1;
      step(S_ID, 2'd0);
      bus.err_clear = 1'b0;

      // Align arrives with counter at zero.
      bus.align_timeout = 16'd1;
      step(S_WP, 2'd0);
      step(S_SE, 2'd0);
      step(S_WA, 2'd0);
      step(S_WA, 2'd0);
      bus.rx_align_done = 1'b1;
      step(S_ON, 2'd0);

      // Abort during SETTLE.
      bus.rx_align_done = 1'b0;
      bus.settle_value  = 16'd4;
      bus.link_en       = 1'b0;
      step(S_ID, 2'd0);
      bus.link_en = 1'b1;
      step(S_WP, 2'd0);
      step(S_SE, 2'd0);
      step(S_SE, 2'd0);
      bus.link_en = 1'b0;
      step(S_ID, 2'd0);

      // Back to ONLINE, then async reset.
      bus.link_en       = 1'b1;
      bus.settle_value  = 16'd0;
      bus.rx_align_done = 1'b1;
      step(S_WP, 2'd0);
      step(S_SE, 2'd0);
      step(S_WA, 2'd0);
      step(S_ON, 2'd0);
      #2;
      rst_wr_n = 1'b0;
      #1;
      chk_outs("arst", S_ID, 2'd0);
      #2;
      rst_wr_n = 1'b1;
      #1;
      chk_outs("arel", S_ID, 2'd0);
      step(S_WP, 2'd0);
      step(S_SE, 2'd0);

      chk("sb_drain", 16'(sb.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/lpif_link_seq.md
LPIF_LINK_SEQ -- requirements
Module: lpif_link_seq

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: number of retrain attempts allowed before entering ERROR.
REQ-002 SHALL have port clk_wr, input, 1: the only clock; all state is on its rising edge.
REQ-003 SHALL have port rst_wr_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port link_en, input, 1: enables link bring-up when 1.
REQ-005 SHALL have port phy_ready, input, 1: PHY transfer ready.
REQ-006 SHALL have port rx_align_done, input, 1: receive marker/strobe alignment locked.
REQ-007 SHALL have port settle_value, input, 16: tx settle cycles minus 1.
REQ-008 SHALL have port align_timeout, input, 16: alignment wait cycles minus 1.
REQ-009 SHALL have port err_clear, input, 1: exits ERROR.
REQ-010 SHALL have port tx_online, output, 1: drives the datapath tx_online input.
REQ-011 SHALL have port rx_online, output, 1: drives the datapath rx_online input.
REQ-012 SHALL have port link_up, output, 1: link is in ONLINE.
REQ-013 SHALL have port link_err, output, 1: link is in ERROR.
REQ-014 SHALL have port retry_cnt, output, 2: retrain attempts made.
REQ-015 SHALL have port link_state, output, 3: current state encoding, for debug.

Function
REQ-016 SHALL implement a Moore FSM with these state encodings: IDLE=0, WAIT_PHY=1, SETTLE=2, WAIT_ALIGN=3, ONLINE=4, RETRY=5, ERROR=6.
REQ-017 SHALL decode all outputs from registered state only, with no input-to-output combinational path.
REQ-018 SHALL drive tx_online=1 in states SETTLE, WAIT_ALIGN and ONLINE, and 0 in all other states.
REQ-019 SHALL drive rx_online=1 and link_up=1 only in ONLINE.
REQ-020 SHALL drive link_err=1 only in ERROR.
REQ-021 SHALL implement IDLE -> WAIT_PHY when link_en=1.
REQ-022 SHALL implement WAIT_PHY -> SETTLE when phy_ready=1, loading a 16-bit counter with settle_value.
REQ-023 SHALL, in SETTLE, decrement the counter each cycle and go to WAIT_ALIGN when the counter is 0, reloading it with align_timeout.
REQ-024 SHALL, in WAIT_ALIGN, go to ONLINE when rx_align_done=1; otherwise go to RETRY when the counter is 0; otherwise decrement the counter.
REQ-025 SHALL, in WAIT_ALIGN, give rx_align_done=1 priority when it occurs together with counter==0 (go to ONLINE).
REQ-026 SHALL implement ONLINE -> RETRY when rx_align_done=0 or phy_ready=0.
REQ-027 SHALL make RETRY last exactly 1 cycle with all online outputs at 0.
REQ-028 SHALL, leaving RETRY, go to ERROR if retry_cnt==MAX_RETRY; otherwise increment retry_cnt and go to WAIT_PHY.
REQ-029 SHALL implement ERROR -> IDLE when err_clear=1, and otherwise hold ERROR regardless of link_en.
REQ-030 SHALL force a transition to IDLE next cycle when link_en=0 in any state except ERROR, with priority over all other transitions.
REQ-031 SHALL clear retry_cnt on entry to IDLE, hold it otherwise, and never let it exceed MAX_RETRY.
REQ-032 SHALL sample settle_value and align_timeout only at counter load; changes mid-count have no effect.
REQ-033 SHALL give tx_online = settle_value+1 cycles before WAIT_ALIGN, so settle_value=0 gives a 1-cycle SETTLE.
REQ-034 SHALL give an alignment window of align_timeout+1 cycles, so align_timeout=0 gives a 1-cycle window.
REQ-035 SHALL keep the latency from phy_ready=1 (sampled in WAIT_PHY) to tx_online=1 at 1 cycle.
REQ-036 SHALL keep the latency from rx_align_done=1 (sampled in WAIT_ALIGN) to rx_online=1 at 1 cycle.

Reset
REQ-037 SHALL, on rst_wr_n=0, immediately and asynchronously set state=IDLE, counter=0 and retry_cnt=0, with all outputs 0 and link_state=0.
REQ-038 SHALL leave IDLE no earlier than the first clock edge after reset release.
REQ-039 SHALL, on reset asserted mid-operation (including ONLINE), drop tx_online and rx_online without waiting for a clock edge.

Verification
REQ-040 SHALL verify the nominal sequence: link_en=1, phy_ready=1, settle_value=4, rx_align_done rising 2 cycles into WAIT_ALIGN -> tx_online high 5 cycles before WAIT_ALIGN, rx_online and link_up high 1 cycle after the align sample, retry_cnt=0.
REQ-041 SHALL verify the timeout path: align_timeout=2 with rx_align_done=0 -> RETRY after 3 WAIT_ALIGN cycles, 1 cycle with all online outputs 0, then WAIT_PHY with retry_cnt=1; four consecutive failures -> ERROR with link_err=1 and retry_cnt=3.
REQ-042 SHALL verify the simultaneous case: rx_align_done=1 in the same cycle the counter reaches 0 -> ONLINE, not RETRY.
REQ-043 SHALL verify loss of lock: in ONLINE drop rx_align_done for 1 cycle -> RETRY, then WAIT_PHY, with retry_cnt incremented.
REQ-044 SHALL verify ERROR exit: link_en toggled while in ERROR -> state stays ERROR; err_clear=1 -> IDLE next cycle with retry_cnt=0.
REQ-045 SHALL verify the abort paths: link_en=0 during SETTLE -> IDLE next cycle; rst_wr_n pulsed low in ONLINE -> outputs 0 asynchronously and link_state=0.
